fb_burst_writer: RTL and testbench
==================================

FB_BURST_WRITER -- requirements
Module: fb_burst_writer

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, giving the maximum beats per AXI4 write burst (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 32, giving the AXI address width.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_addr (input, ADDR_W: framebuffer byte start address) and cmd_len (input, 16: pixel word count).
REQ-006 SHALL have ports pix_valid (input, 1), pix_ready (output, 1) and pix_data (input, 32): the pixel word stream.
REQ-007 SHALL have AXI4 AW ports: m_axi_awaddr (output, ADDR_W), m_axi_awlen (output, 8), m_axi_awsize (output, 3), m_axi_awburst (output, 2), m_axi_awvalid (output, 1), m_axi_awready (input, 1).
REQ-008 SHALL have AXI4 W ports: m_axi_wdata (output, 32), m_axi_wstrb (output, 4), m_axi_wlast (output, 1), m_axi_wvalid (output, 1), m_axi_wready (input, 1).
REQ-009 SHALL have AXI4 B ports: m_axi_bresp (input, 2), m_axi_bvalid (input, 1), m_axi_bready (output, 1).
REQ-010 SHALL have status outputs busy (1), done (1, one-cycle pulse) and err (1, sticky).

Function
REQ-011 SHALL implement FSM states IDLE, AW, W, B.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-013 SHALL latch cmd_addr with bits[1:0] forced to 0, latch cmd_len as remaining count, and clear err on acceptance.
REQ-014 With cmd_len=0: SHALL stay in IDLE, pulse done in the next cycle, and generate no AXI traffic.
REQ-015 SHALL compute burst beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/4), so no burst crosses a 4 KB boundary.
REQ-016 In AW: SHALL hold awvalid=1 with awaddr=current address, awlen=beats-1, awsize=3'b010, awburst=2'b01 stable until awready; then go to W.
REQ-017 In W: SHALL set wvalid=pix_valid, pix_ready=wready, wdata=pix_data, wstrb=4'hF; pix_ready=0 in all other states.
REQ-018 SHALL assert wlast on the beat whose index equals beats-1; after the wlast handshake SHALL go to B.
REQ-019 SHALL transmit pixel words in order, with no drop or duplication under any valid/ready pattern.
REQ-020 In B: SHALL hold bready=1; on bvalid, bresp[1]=1 (SLVERR/DECERR) SHALL set err, and the transfer SHALL continue.
REQ-021 On the B handshake: SHALL add beats*4 to address and subtract beats from remaining; if remaining>0 go to AW, else go to IDLE and pulse done in the following cycle.
REQ-022 SHALL keep only one burst outstanding: no AW is issued before the previous B.
REQ-023 SHALL drive busy=1 in every non-IDLE state.
REQ-024 SHALL handle the 16-bit length and address arithmetic without overflow; an address wrap at 2^ADDR_W is not checked.

Reset
REQ-025 On areset=1 SHALL enter IDLE immediately; awvalid, wvalid, wlast, bready, pix_ready, busy, done and err reset to 0, counters and address registers reset to 0, and cmd_ready=1 after release.
REQ-026 On reset mid-burst SHALL abandon the burst without completing it; the interconnect is reset alongside.

Verification
REQ-027 cmd_addr=0x10000000, len=5 -> one AW with awaddr=0x10000000, awlen=4; 5 W beats with wlast on the 5th; one B; done pulse; err=0.
REQ-028 addr=0x10000000, len=40 -> bursts awlen 15/15/7 at 0x10000000/0x10000040/0x10000080; 40 beats in order; a single done pulse.
REQ-029 addr=0x10000FF0, len=8 -> awlen=3 at 0x10000FF0, then awlen=3 at 0x10001000.
REQ-030 len=0 -> done in the next cycle; awvalid never asserted; busy stays 0.
REQ-031 Random pix_valid/wready/awready/bvalid stalls, 100-word transfer -> data matches the input sequence in the memory model; exactly 7 bursts.
REQ-032 bresp=2'b10 on the 2nd of 3 bursts -> err=1, the 3rd burst still issued, done pulses; the next command clears err. Reset asserted mid-W -> all valids 0 in the same cycle, IDLE after release.

Source files
------------

// File: rtl/fb_burst_writer.sv
// Framebuffer burst writer: turns a (start address, word count) command plus a
// pixel word stream into 4 KB-safe AXI4 INCR write bursts, one burst in flight.
module fb_burst_writer #(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_len,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [31:0]       pix_data,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_t;

  localparam logic [15:0]       MAX_LEN    = 16'(MAX_BURST);
  localparam logic [8:0]        MAX_BEATS  = 9'(MAX_BURST);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [8:0]        beat_cnt;

  logic [10:0]       to_boundary;
  logic [8:0]        len_cap;
  logic [8:0]        beats;
  logic              last_beat;
  logic              cmd_fire;
  logic              w_fire;
  logic              b_fire;
  logic              b_is_err;
  logic              xfer_last;

  // Burst size: limited by words left, MAX_BURST and the words left in this 4 KB page.
  always_comb begin
    to_boundary = 11'd1024 - {1'b0, addr[11:2]};
    if (remaining >= MAX_LEN) begin
      len_cap = MAX_BEATS;
    end else begin
      len_cap = remaining[8:0];
    end
    if ({2'b00, len_cap} > to_boundary) begin
      beats = to_boundary[8:0];
    end else begin
      beats = len_cap;
    end
  end

  assign cmd_fire  = cmd_valid && (state == IDLE);
  assign w_fire    = (state == W) && pix_valid && m_axi_wready;
  assign b_fire    = (state == B) && m_axi_bvalid;
  assign last_beat = (beat_cnt == (beats - 9'd1));
  assign xfer_last = (remaining == {7'd0, beats});
  assign b_is_err  = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid && (cmd_len != 16'd0)) begin
          state_next = AW;
        end else begin
          state_next = IDLE;
        end
      end
      AW: begin
        if (m_axi_awready) begin
          state_next = W;
        end else begin
          state_next = AW;
        end
      end
      W: begin
        if (w_fire && last_beat) begin
          state_next = B;
        end else begin
          state_next = W;
        end
      end
      B: begin
        if (m_axi_bvalid) begin
          if (xfer_last) begin
            state_next = IDLE;
          end else begin
            state_next = AW;
          end
        end else begin
          state_next = B;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address, word count, beat counter and status registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr      <= '0;
      remaining <= 16'd0;
      beat_cnt  <= 9'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      if (cmd_fire) begin
        addr      <= cmd_addr & ALIGN_MASK;
        remaining <= cmd_len;
        beat_cnt  <= 9'd0;
        err       <= 1'b0;
        done      <= (cmd_len == 16'd0);
      end
      if (w_fire) begin
        if (last_beat) begin
          beat_cnt <= 9'd0;
        end else begin
          beat_cnt <= beat_cnt + 9'd1;
        end
      end
      // An error response is recorded but the transfer keeps going.
      if (b_fire) begin
        addr      <= addr + ADDR_W'({beats, 2'b00});
        remaining <= remaining - {7'd0, beats};
        if (b_is_err) begin
          err <= 1'b1;
        end
        if (xfer_last) begin
          done <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign m_axi_awvalid = (state == AW);
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = beats[7:0] - 8'd1;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = (state == W) && pix_valid;
  assign pix_ready     = (state == W) && m_axi_wready;
  assign m_axi_wdata   = pix_data;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = (state == W) && last_beat;
  assign m_axi_bready  = (state == B);

endmodule

// File: tb/tb_fb_burst_writer.sv
// Bench for fb_burst_writer: random-stall AXI slave with a memory model, and a
// reference burst splitter computed directly from the addressing rules.
module tb_fb_burst_writer;

  localparam int MAX_BURST = 16;
  localparam int ADDR_W    = 32;

  logic              aclk = 1'b0;
  logic              areset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_len;
  logic              pix_valid;
  logic              pix_ready;
  logic [31:0]       pix_data;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              busy;
  logic              done;
  logic              err;

  fb_burst_writer #(.MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  bit          stall;
  int          err_burst;
  logic [31:0] pix_q[$];
  int          pix_idx;
  logic [31:0] mem[logic [31:0]];
  logic [31:0] aw_addr_q[$];
  int          aw_len_q[$];
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [31:0] cur_awaddr;
  int          cur_len;
  int          beat_idx;
  int          aw_cnt, b_cnt, w_cnt, done_cnt, b_pending;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave, pixel source and monitor: sample mid-cycle, drive 2 time units after the edge.
  initial begin
    bit pf, bf;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    pix_valid = 1'b0; pix_data = 32'd0;
    forever begin
      @(negedge aclk);
      pf = 1'b0;
      bf = 1'b0;
      if (!areset) begin
        if (awvalid && awready) begin
          check("aw_outstanding", 64'(aw_cnt - b_cnt), 64'd0);
          check("awsize", 64'(awsize), 64'd2);
          check("awburst", 64'(awburst), 64'd1);
          aw_addr_q.push_back(awaddr);
          aw_len_q.push_back(int'(awlen));
          cur_awaddr = awaddr;
          cur_len    = int'(awlen);
          beat_idx   = 0;
          aw_cnt++;
        end
        if (wvalid && wready) begin
          mem[cur_awaddr + 32'(beat_idx * 4)] = wdata;
          check("wstrb", 64'(wstrb), 64'hF);
          check("wlast", 64'(wlast), 64'(beat_idx == cur_len));
          if (wlast) b_pending++;
          beat_idx++;
          w_cnt++;
        end
        pf = pix_valid && pix_ready;
        if (bvalid && bready) begin
          bf = 1'b1;
          b_cnt++;
          b_pending--;
        end
        if (done) done_cnt++;
      end
      @(posedge aclk);
      #2;
      if (pf) pix_idx++;
      pix_valid = (pix_idx < pix_q.size()) && (!stall || ($urandom_range(0, 2) != 0));
      pix_data  = pix_valid ? pix_q[pix_idx] : 32'd0;
      awready   = !stall || ($urandom_range(0, 2) == 0);
      wready    = !stall || ($urandom_range(0, 1) == 0);
      if (!(bvalid && !bf)) begin
        bvalid = (b_pending > 0) && (!stall || ($urandom_range(0, 2) == 0));
      end
      bresp = (b_cnt == err_burst) ? 2'b10 : 2'b00;
    end
  end

  // Sets up data, the expected burst list and clears the monitor, mid-cycle.
  task automatic prep(input logic [31:0] a, input int len, input bit st, input int eb);
    int          rem;
    logic [31:0] ad;
    @(negedge aclk);
    #1;
    exp_addr.delete();
    exp_len.delete();
    rem = len;
    ad  = a & 32'hFFFF_FFFC;
    while (rem > 0) begin
      int room, b;
      room = (4096 - int'(ad[11:0])) / 4;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      exp_addr.push_back(ad);
      exp_len.push_back(b - 1);
      ad  = ad + 32'(4 * b);
      rem = rem - b;
    end
    pix_q.delete();
    for (int i = 0; i < len; i++) pix_q.push_back($urandom);
    pix_idx = 0;
    mem.delete();
    aw_addr_q.delete();
    aw_len_q.delete();
    aw_cnt = 0; b_cnt = 0; w_cnt = 0; done_cnt = 0; b_pending = 0;
    err_burst = eb;
    stall = st;
  endtask

  task automatic send_cmd(input logic [31:0] a, input int len);
    @(posedge aclk);
    #2;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 16'(len);
    @(negedge aclk);
    check("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] a, input int len, input bit st, input int eb);
    int          cyc;
    logic [31:0] base;
    prep(a, len, st, eb);
    send_cmd(a, len);
    @(negedge aclk);
    check("err_cleared", 64'(err), 64'd0);
    check("busy_run", 64'(busy), 64'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      @(negedge aclk);
      cyc++;
    end
    check("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (4) @(negedge aclk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("busy_end", 64'(busy), 64'd0);
    check("burst_count", 64'(aw_cnt), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < aw_addr_q.size(); i++) begin
      check("awaddr", 64'(aw_addr_q[i]), 64'(exp_addr[i]));
      check("awlen", 64'(aw_len_q[i]), 64'(exp_len[i]));
    end
    check("beat_count", 64'(w_cnt), 64'(len));
    base = a & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      logic [31:0] k;
      k = base + 32'(4 * i);
      check("mem_data", mem.exists(k) ? 64'(mem[k]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(pix_q[i]));
    end
    check("err_final", 64'(err), 64'((eb >= 0) && (eb < exp_addr.size())));
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int cyc;
    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 32'd0;
    cmd_len   = 16'd0;
    stall     = 1'b0;
    err_burst = -1;
    repeat (3) @(negedge aclk);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_wlast", 64'(wlast), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge aclk);
    #2;
    areset = 1'b0;
    @(negedge aclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    run_xfer(32'h1000_0000, 5, 1'b0, -1);
    run_xfer(32'h1000_0000, 40, 1'b0, -1);
    run_xfer(32'h1000_0FF0, 8, 1'b0, -1);

    // Zero-length command: done next cycle, no traffic, never busy.
    prep(32'h1000_0000, 0, 1'b0, -1);
    send_cmd(32'h1000_0000, 0);
    @(negedge aclk);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_awvalid", 64'(awvalid), 64'd0);
    @(negedge aclk);
    check("len0_done_drop", 64'(done), 64'd0);
    repeat (3) @(negedge aclk);
    check("len0_no_aw", 64'(aw_cnt), 64'd0);
    check("len0_done_once", 64'(done_cnt), 64'd1);

    run_xfer(32'h1000_0000, 100, 1'b1, -1);
    run_xfer(32'h2000_0000 | ($urandom & 32'h0000_3FFC), $urandom_range(1, 300), 1'b1, -1);
    run_xfer(32'h1000_0000, 40, 1'b1, 1);
    run_xfer(32'h1000_0000, 5, 1'b0, -1);

    // Reset during the data phase.
    prep(32'h1000_0000, 40, 1'b0, -1);
    send_cmd(32'h1000_0000, 40);
    cyc = 0;
    while (!wvalid && cyc < 100) begin
      @(negedge aclk);
      cyc++;
    end
    check("midw_reached", 64'(wvalid), 64'd1);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check("midrst_awvalid", 64'(awvalid), 64'd0);
    check("midrst_wvalid", 64'(wvalid), 64'd0);
    check("midrst_wlast", 64'(wlast), 64'd0);
    check("midrst_bready", 64'(bready), 64'd0);
    check("midrst_pix_ready", 64'(pix_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    pix_q.delete();
    pix_idx   = 0;
    b_pending = 0;
    repeat (2) @(negedge aclk);
    @(posedge aclk);
    #2;
    areset = 1'b0;
    @(negedge aclk);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_idle_busy", 64'(busy), 64'd0);
    run_xfer(32'h1000_0100, 20, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
